// File: rtl/regfile_mp_if.sv
// Bundled read/write port signals for the multi-port register file.
// The master drives addresses, enables and write data; the slave returns registered read data.
interface regfile_mp_if #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
);
  localparam int AW = $clog2(DEPTH);

  logic [NUM_RD-1:0]       rd_en;
  logic [NUM_RD*AW-1:0]    rd_addr;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic [NUM_WR-1:0]       wr_en;
  logic [NUM_WR*AW-1:0]    wr_addr;
  logic [NUM_WR*WIDTH-1:0] wr_data;
  logic                    wr_conflict;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data, wr_conflict
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data, wr_conflict
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD registered read ports, NUM_WR prioritised write ports
// (highest index wins), write-first bypass and an optional hardwired-zero register 0.
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);
  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
  localparam bit            HAS_ZERO  = (ZERO_REG != 0);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "regfile_mp: DEPTH must be a power of 2 and at least 2");
  end
  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $fatal(1, "regfile_mp: NUM_RD must be 1 to 4");
  end
  if (NUM_WR < 1 || NUM_WR > 3) begin : g_bad_num_wr
    $fatal(1, "regfile_mp: NUM_WR must be 1 to 3");
  end

  logic [AW-1:0]           wa      [NUM_WR];
  logic [WIDTH-1:0]        wd      [NUM_WR];
  logic [AW-1:0]           ra      [NUM_RD];
  logic [WIDTH-1:0]        rd_next [NUM_RD];
  logic [WIDTH-1:0]        mem     [DEPTH];
  logic [NUM_WR-1:0]       wr_live;
  logic [NUM_WR-1:0]       wr_win;
  logic                    collide;
  logic [NUM_RD*WIDTH-1:0] rd_q;
  logic                    conflict_q;

  // A write is live when enabled and not aimed at a hardwired-zero register 0.
  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
    assign wa[j]      = bus.wr_addr[j*AW +: AW];
    assign wd[j]      = bus.wr_data[j*WIDTH +: WIDTH];
    assign wr_live[j] = bus.wr_en[j] & ~(HAS_ZERO & (wa[j] == ADDR_ZERO));
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign ra[i] = bus.rd_addr[i*AW +: AW];
  end

  // Priority resolution: a live port loses to any higher-index live port on the same address.
  always_comb begin
    wr_win  = wr_live;
    collide = 1'b0;
    for (int j = 0; j < NUM_WR; j++) begin
      for (int k = j + 1; k < NUM_WR; k++) begin
        wr_win[j] = wr_win[j] & ~(wr_live[j] & wr_live[k] & (wa[j] == wa[k]));
        collide   = collide | (wr_live[j] & wr_live[k] & (wa[j] == wa[k]));
      end
    end
  end

  // Effective read value; ascending scan lets the highest-index matching write win the bypass.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_next[i] = mem[ra[i]];
      for (int j = 0; j < NUM_WR; j++) begin
        rd_next[i] = (wr_live[j] && (wa[j] == ra[i])) ? wd[j] : rd_next[i];
      end
      rd_next[i] = (HAS_ZERO && (ra[i] == ADDR_ZERO)) ? {WIDTH{1'b0}} : rd_next[i];
    end
  end

  // Storage, read lanes and conflict flag; reset discards all same-cycle traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < DEPTH; d++) begin
        mem[d] <= {WIDTH{1'b0}};
      end
      rd_q       <= {(NUM_RD*WIDTH){1'b0}};
      conflict_q <= 1'b0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_win[j]) begin
          mem[wa[j]] <= wd[j];
        end
      end
      for (int i = 0; i < NUM_RD; i++) begin
        if (bus.rd_en[i]) begin
          rd_q[i*WIDTH +: WIDTH] <= rd_next[i];
        end
      end
      conflict_q <= collide;
    end
  end

  assign bus.rd_data     = rd_q;
  assign bus.wr_conflict = conflict_q;
endmodule
